// File: rtl/minimig_host_seq.sv
// Byte-serial host command sequencer: parks the 68000 via cpu_halt and runs word
// cycles on the bridge host port, streaming write data in and read data out.
module minimig_host_seq #(
    parameter int HALT_DELAY  = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic        cpu_halt,
    output logic        host_cs,
    output logic [22:0] host_adr,
    output logic        host_we,
    output logic [1:0]  host_bs,
    output logic [15:0] host_wdat,
    input  logic [15:0] host_rdat,
    input  logic        host_ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, ADR2, ADR1, ADR0, CNT, WHI, WLO, HALTW, CYC, GAP, RHI, RLO, DONE
    } state_t;

    localparam logic [7:0]  HALT_LAST = 8'(HALT_DELAY - 1);
    localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [22:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic        first_q, first_d;
    logic [7:0]  halt_cnt_q, halt_cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        gap_q, gap_d;
    logic        err_q, err_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        host_cs_q, host_cs_d;
    logic        host_we_q, host_we_d;
    logic [1:0]  host_bs_q, host_bs_d;
    logic        rx_ready_q, rx_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        busy_q, busy_d;
    logic        rx_acc_s, tx_acc_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        first_d    = first_q;
        halt_cnt_d = 8'd0;
        tmo_d      = 16'd0;
        gap_d      = 1'b0;
        err_d      = err_q;
        rx_acc_s   = rx_valid & rx_ready_q;
        tx_acc_s   = tx_valid_q & tx_ready;

        case (state_q)
            IDLE: begin
                if (rx_acc_s) begin
                    case (rx_byte)
                        8'h00: err_d = 1'b0;
                        8'h01: state_d = ADR2;
                        8'h02: begin op_wr_d = 1'b1; state_d = CNT; end
                        8'h03: begin op_wr_d = 1'b0; state_d = CNT; end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ADR2: begin
                if (rx_acc_s) begin adr_d[22:15] = rx_byte; state_d = ADR1; end
                else          begin state_d = ADR2; end
            end
            ADR1: begin
                if (rx_acc_s) begin adr_d[14:7] = rx_byte; state_d = ADR0; end
                else          begin state_d = ADR1; end
            end
            ADR0: begin
                if (rx_acc_s) begin adr_d[6:0] = rx_byte[7:1]; state_d = IDLE; end
                else          begin state_d = ADR0; end
            end
            CNT: begin
                if (rx_acc_s) begin
                    cnt_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    first_d = 1'b1;
                    state_d = op_wr_q ? WHI : HALTW;
                end else begin
                    state_d = CNT;
                end
            end
            WHI: begin
                if (rx_acc_s) begin wdat_d[15:8] = rx_byte; state_d = WLO; end
                else          begin state_d = WHI; end
            end
            WLO: begin
                if (rx_acc_s) begin
                    wdat_d[7:0] = rx_byte;
                    first_d     = 1'b0;
                    state_d     = first_q ? HALTW : CYC;
                end else begin
                    state_d = WLO;
                end
            end
            HALTW: begin
                // Give the bridge HALT_DELAY 7 MHz ticks to park the CPU
                if (clk7_en) begin
                    if (halt_cnt_q == HALT_LAST) state_d = CYC;
                    else                         halt_cnt_d = halt_cnt_q + 8'd1;
                end else begin
                    halt_cnt_d = halt_cnt_q;
                end
            end
            CYC: begin
                if (host_ack) begin
                    rdat_d  = host_rdat;
                    adr_d   = adr_q + 23'd1;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GAP: begin
                // Require one clk7_en after the first gap clock so _as re-syncs
                if (clk7_en && gap_q) begin
                    if (!op_wr_q)            state_d = RHI;
                    else if (cnt_q != 9'd0)  state_d = WHI;
                    else                     state_d = DONE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            RHI: begin
                if (tx_acc_s) state_d = RLO;
                else          state_d = RHI;
            end
            RLO: begin
                if (tx_acc_s) state_d = (cnt_q != 9'd0) ? CYC : DONE;
                else          state_d = RLO;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        host_cs_d  = (state_d == CYC);
        host_we_d  = (state_d == CYC) & op_wr_d;
        host_bs_d  = (state_d == CYC) ? 2'b11 : 2'b00;
        busy_d     = (state_d != IDLE);
        rx_ready_d = (state_d inside {IDLE, ADR2, ADR1, ADR0, CNT, WHI, WLO});
        tx_valid_d = (state_d inside {RHI, RLO});
        cpu_halt_d = (state_d == HALTW) ? 1'b1 :
                     (state_d inside {IDLE, DONE}) ? 1'b0 : cpu_halt_q;
        case (state_d)
            RHI:     tx_byte_d = rdat_d[15:8];
            RLO:     tx_byte_d = rdat_d[7:0];
            default: tx_byte_d = tx_byte_q;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            adr_q      <= 23'd0;
            wdat_q     <= 16'd0;
            rdat_q     <= 16'd0;
            cnt_q      <= 9'd0;
            op_wr_q    <= 1'b0;
            first_q    <= 1'b0;
            halt_cnt_q <= 8'd0;
            tmo_q      <= 16'd0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
            cpu_halt_q <= 1'b0;
            host_cs_q  <= 1'b0;
            host_we_q  <= 1'b0;
            host_bs_q  <= 2'b00;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            first_q    <= first_d;
            halt_cnt_q <= halt_cnt_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            cpu_halt_q <= cpu_halt_d;
            host_cs_q  <= host_cs_d;
            host_we_q  <= host_we_d;
            host_bs_q  <= host_bs_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_byte   = tx_byte_q;
    assign cpu_halt  = cpu_halt_q;
    assign host_cs   = host_cs_q;
    assign host_adr  = adr_q;
    assign host_we   = host_we_q;
    assign host_bs   = host_bs_q;
    assign host_wdat = wdat_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
